// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder feeding the sha256 core one 512-bit block per core run.
// Optional `SHA256_PADDER_BIG_ENDIAN_EN: input beats carry the first byte in [31:24].
module sha256_padder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_nbytes,
  output logic        dat_vaild_o,
  output logic [31:0] dat_lsb_o,
  input  logic        irq_finish_i,
  output logic        first_blk_o,
  output logic        msg_done_o
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT} state_t;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t      state, state_nxt;
  logic [31:0] blk [16];
  logic [3:0]  widx, widx_nxt;
  logic [3:0]  scnt, scnt_nxt;
  logic [60:0] nbyte, nbyte_nxt;
  logic        mark_done, mark_nxt;
  logic        len_hi, len_hi_nxt;
  logic        len_done, len_done_nxt;
  logic        in_done, in_done_nxt;
  logic        first, first_nxt;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] din, din_mask;
  logic [63:0] bits;
  logic        beat_in;
  logic        ready_nxt, vld_nxt, first_blk_nxt, done_nxt;
  logic [31:0] dat_nxt;

`ifdef SHA256_PADDER_BIG_ENDIAN_EN
  assign din = bswap(s_data);
`else
  assign din = s_data;
`endif

  assign bits    = {nbyte, 3'b000};
  assign beat_in = s_valid & s_ready;

  // Short last beat: clear unused lanes and drop the 0x80 marker right after the data.
  always_comb begin
    din_mask = din;
    for (int unsigned k = 0; k < 4; k++) begin
      if (s_last && (3'(k) >= s_nbytes))
        din_mask[8*k +: 8] = (3'(k) == s_nbytes) ? 8'h80 : 8'h00;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_en        = 1'b0;
    wr_data      = '0;
    widx_nxt     = widx;
    scnt_nxt     = scnt;
    nbyte_nxt    = nbyte;
    mark_nxt     = mark_done;
    len_hi_nxt   = len_hi;
    len_done_nxt = len_done;
    in_done_nxt  = in_done;
    first_nxt    = first;
    done_nxt     = 1'b0;
    vld_nxt      = 1'b0;
    dat_nxt      = '0;
    unique case (state)
      IDLE, FILL: begin
        if (beat_in) begin
          nbyte_nxt = nbyte + {58'b0, s_nbytes};
          if (s_last && s_nbytes == 3'd0) begin
            // Empty last beat carries no data; PAD places the marker at widx.
            in_done_nxt = 1'b1;
            state_nxt   = PAD;
          end else begin
            wr_en    = 1'b1;
            wr_data  = din_mask;
            widx_nxt = widx + 4'd1;
            if (s_last) begin
              in_done_nxt = 1'b1;
              mark_nxt    = (s_nbytes < 3'd4);
              state_nxt   = (widx == 4'd15) ? SEND : PAD;
            end else begin
              state_nxt = (widx == 4'd15) ? SEND : FILL;
            end
          end
        end
      end
      PAD: begin
        wr_en    = 1'b1;
        widx_nxt = widx + 4'd1;
        if (!mark_done) begin
          wr_data  = 32'h0000_0080;
          mark_nxt = 1'b1;
        end else if (widx == 4'd14) begin
          wr_data    = bswap(bits[63:32]);
          len_hi_nxt = 1'b1;
        end else if (widx == 4'd15 && len_hi) begin
          // Low length word only follows a high word placed in this same block.
          wr_data      = bswap(bits[31:0]);
          len_done_nxt = 1'b1;
        end
        if (widx == 4'd15)
          state_nxt = SEND;
      end
      SEND: begin
        vld_nxt  = 1'b1;
        dat_nxt  = blk[scnt];
        scnt_nxt = scnt + 4'd1;
        if (scnt == 4'd15)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (irq_finish_i) begin
          first_nxt = 1'b0;
          widx_nxt  = '0;
          if (len_done) begin
            done_nxt     = 1'b1;
            first_nxt    = 1'b1;
            nbyte_nxt    = '0;
            mark_nxt     = 1'b0;
            len_hi_nxt   = 1'b0;
            len_done_nxt = 1'b0;
            in_done_nxt  = 1'b0;
            state_nxt    = IDLE;
          end else if (!in_done) begin
            state_nxt = FILL;
          end else begin
            state_nxt = PAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt     = (state_nxt == IDLE) || (state_nxt == FILL);
    first_blk_nxt = first && (state == SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      widx        <= '0;
      scnt        <= '0;
      nbyte       <= '0;
      mark_done   <= 1'b0;
      len_hi      <= 1'b0;
      len_done    <= 1'b0;
      in_done     <= 1'b0;
      first       <= 1'b1;
      s_ready     <= 1'b0;
      dat_vaild_o <= 1'b0;
      dat_lsb_o   <= '0;
      first_blk_o <= 1'b0;
      msg_done_o  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++)
        blk[i] <= '0;
    end else begin
      state       <= state_nxt;
      widx        <= widx_nxt;
      scnt        <= scnt_nxt;
      nbyte       <= nbyte_nxt;
      mark_done   <= mark_nxt;
      len_hi      <= len_hi_nxt;
      len_done    <= len_done_nxt;
      in_done     <= in_done_nxt;
      first       <= first_nxt;
      s_ready     <= ready_nxt;
      dat_vaild_o <= vld_nxt;
      dat_lsb_o   <= dat_nxt;
      first_blk_o <= first_blk_nxt;
      msg_done_o  <= done_nxt;
      if (wr_en)
        blk[widx] <= wr_data;
    end
  end

endmodule
